// File: rtl/ahb_slave_pkg.sv
// ---------------------------------------------------------------------------
// ahb_slave_pkg
// Shared definitions for the tx buffer peripheral AHB-Lite slave front end:
//   - state_t      : data-phase controller states
//   - HTRANS_*     : AHB transfer type encodings
//   - HSIZE_*      : AHB transfer size encodings
//   - ADDR_*       : slave-local register map base addresses
//   - is_ro()      : 1 for read-only register locations
// Configuration macro: AHB_ERR_RESP_EN (adds the ERR1/ERR2 states).
// ---------------------------------------------------------------------------
package ahb_slave_pkg;

`ifdef AHB_ERR_RESP_EN
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA,
      ST_WAIT,
      ST_ERR1,
      ST_ERR2
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA,
      ST_WAIT
   } state_t;
`endif

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [1:0] HSIZE_BYTE    = 2'd0;
   localparam logic [1:0] HSIZE_HALF    = 2'd1;
   localparam logic [1:0] HSIZE_WORD    = 2'd2;
   localparam logic [1:0] HSIZE_ILLEGAL = 2'd3;

   // Register map (low nibble of the slave-local address)
   localparam logic [3:0] ADDR_BUF     = 4'h0;  // 0x0-0x3 data buffer, RW
   localparam logic [3:0] ADDR_STATUS  = 4'h4;  // 0x4-0x5 status, RO
   localparam logic [3:0] ADDR_ERROR   = 4'h6;  // 0x6-0x7 error, RO
   localparam logic [3:0] ADDR_OCCUP   = 4'h8;  // 0x8 occupancy, RO
   localparam logic [3:0] ADDR_TX_CTRL = 4'hC;  // tx control, RW
   localparam logic [3:0] ADDR_FLUSH   = 4'hD;  // flush, RW

   // Status, error and occupancy form one contiguous read-only window.
   function automatic logic is_ro(input logic [3:0] addr);
      return (addr >= ADDR_STATUS) && (addr <= ADDR_OCCUP);
   endfunction

   // Only NONSEQ and SEQ carry a transfer; IDLE and BUSY are never accepted.
   function automatic logic is_transfer(input logic [1:0] trans);
      return (trans != HTRANS_IDLE) && (trans != HTRANS_BUSY);
   endfunction

endpackage : ahb_slave_pkg

// File: rtl/ahb_access_check.sv
// ---------------------------------------------------------------------------
// ahb_access_check
// Combinational legality check of one AHB access against the register map.
// Ports:
//   addr_i      in  ADDR_W  slave-local byte address
//   size_i      in  2       HSIZE
//   write_i     in  1       1 = write
//   legal_o     out 1       access is mapped, aligned, sized and permitted
//   is_buffer_o out 1       address falls in the data buffer window
// Requires ADDR_W >= 4; any address bit above bit 3 set means unmapped.
// ---------------------------------------------------------------------------
module ahb_access_check
   import ahb_slave_pkg::*;
#(
   parameter int ADDR_W = 4
) (
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [1:0]        size_i,
   input  logic              write_i,
   output logic              legal_o,
   output logic              is_buffer_o
);

   logic [3:0] lo;
   logic       in_range;
   logic       in_buf;
   logic       mapped;
   logic       align_ok;

   assign lo       = addr_i[3:0];
   assign in_range = ((addr_i >> 4) == '0);
   assign in_buf   = in_range && (lo[3:2] == ADDR_BUF[3:2]);

   always_comb begin
      mapped = in_buf || (in_range && (is_ro(lo) || (lo == ADDR_TX_CTRL) || (lo == ADDR_FLUSH)));

      case (size_i)
         HSIZE_BYTE:    align_ok = 1'b1;
         HSIZE_HALF:    align_ok = ~lo[0];
         HSIZE_WORD:    align_ok = (lo[1:0] == 2'b00);
         HSIZE_ILLEGAL: align_ok = 1'b0;
         default:       align_ok = 1'b0;
      endcase

      legal_o     = mapped && align_ok && !(write_i && is_ro(lo));
      is_buffer_o = in_buf;
   end

endmodule : ahb_access_check

// File: rtl/ahb_slave_frontend.sv
// ---------------------------------------------------------------------------
// ahb_slave_frontend
// AHB-Lite slave address/data-phase controller for the tx buffer peripheral.
// Captures the address phase, issues one-cycle read/write strobes to the
// register file, inserts wait states while the data buffer is busy and
// produces error responses for illegal accesses and buffer timeouts.
// Ports:
//   clk          in  1       system clock, rising edge
//   n_rst        in  1       synchronous reset, active low
//   hsel         in  1       slave select
//   htrans       in  2       transfer type
//   hready       in  1       bus HREADY
//   hwrite       in  1       1 = write
//   haddr        in  ADDR_W  byte address
//   hsize        in  2       transfer size
//   buffer_busy  in  1       buffer cannot complete the access this cycle
//   haddr_reg    out ADDR_W  captured address for the data phase
//   hsize_reg    out 2       captured size
//   hwrite_reg   out 1       captured direction
//   wr_en        out 1       write strobe
//   rd_en        out 1       read strobe
//   hreadyout    out 1       slave ready
//   hresp        out 1       0 = OKAY, 1 = ERROR
// Configuration macro: AHB_ERR_RESP_EN
//   defined   : illegal accesses and timeouts get the two-cycle ERROR response
//   undefined : they complete as a single OKAY cycle without a strobe
// ---------------------------------------------------------------------------
module ahb_slave_frontend
   import ahb_slave_pkg::*;
#(
   parameter int ADDR_W   = 4,
   parameter int MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              hsel,
   input  logic [1:0]        htrans,
   input  logic              hready,
   input  logic              hwrite,
   input  logic [ADDR_W-1:0] haddr,
   input  logic [1:0]        hsize,
   input  logic              buffer_busy,
   output logic [ADDR_W-1:0] haddr_reg,
   output logic [1:0]        hsize_reg,
   output logic              hwrite_reg,
   output logic              wr_en,
   output logic              rd_en,
   output logic              hreadyout,
   output logic              hresp
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] haddr_q, haddr_d;
   logic [1:0]        hsize_q, hsize_d;
   logic              hwrite_q, hwrite_d;
   logic              legal_q, legal_d;
   logic              buf_q, buf_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

   logic              accept;
   logic              chk_legal;
   logic              chk_buffer;
   logic              slot_free;   // current data phase (if any) ends this cycle
   logic              strobe;

   assign accept = hsel && is_transfer(htrans) && hready;

   // Legality is judged on the live address-phase inputs and stored with the capture.
   ahb_access_check #(
      .ADDR_W (ADDR_W)
   ) u_access_check (
      .addr_i      (haddr),
      .size_i      (hsize),
      .write_i     (hwrite),
      .legal_o     (chk_legal),
      .is_buffer_o (chk_buffer)
   );

   assign haddr_reg  = haddr_q;
   assign hsize_reg  = hsize_q;
   assign hwrite_reg = hwrite_q;

   // NOTE: every signal written below gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      haddr_d    = haddr_q;
      hsize_d    = hsize_q;
      hwrite_d   = hwrite_q;
      legal_d    = legal_q;
      buf_d      = buf_q;
      wait_cnt_d = '0;
      hreadyout  = 1'b1;
      slot_free  = 1'b0;
      strobe     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            slot_free = 1'b1;
         end

         ST_DATA: begin
            if (!legal_q) begin
               // Only reachable without the ERROR response: complete silently.
               slot_free = 1'b1;
            end else if (buf_q && buffer_busy) begin
               hreadyout  = 1'b0;
               wait_cnt_d = CNT_ONE;
               state_d    = ST_WAIT;
            end else begin
               strobe    = 1'b1;
               slot_free = 1'b1;
            end
         end

         ST_WAIT: begin
            if (!buffer_busy) begin
               strobe    = 1'b1;
               slot_free = 1'b1;
            end else if (wait_cnt_q == CNT_MAX) begin
`ifdef AHB_ERR_RESP_EN
               hreadyout = 1'b0;
               state_d   = ST_ERR1;
`else
               slot_free = 1'b1;
`endif
            end else begin
               // Increment only below CNT_MAX, so the counter saturates there.
               hreadyout  = 1'b0;
               wait_cnt_d = wait_cnt_q + CNT_ONE;
            end
         end

`ifdef AHB_ERR_RESP_EN
         ST_ERR1: begin
            hreadyout = 1'b0;
            state_d   = ST_ERR2;
         end

         ST_ERR2: begin
            slot_free = 1'b1;
         end
`endif

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A completing cycle doubles as the address phase of the next transfer.
      if (slot_free) begin
         state_d = ST_IDLE;
         if (accept) begin
            haddr_d  = haddr;
            hsize_d  = hsize;
            hwrite_d = hwrite;
            legal_d  = chk_legal;
            buf_d    = chk_buffer;
`ifdef AHB_ERR_RESP_EN
            state_d  = chk_legal ? ST_DATA : ST_ERR1;
`else
            state_d  = ST_DATA;
`endif
         end
      end

      // Gated by n_rst so a transfer abandoned by reset never strobes.
      wr_en = strobe && hwrite_q && n_rst;
      rd_en = strobe && !hwrite_q && n_rst;
   end

`ifdef AHB_ERR_RESP_EN
   assign hresp = (state_q == ST_ERR1) || (state_q == ST_ERR2);
`else
   assign hresp = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q    <= ST_IDLE;
         haddr_q    <= '0;
         hsize_q    <= '0;
         hwrite_q   <= 1'b0;
         legal_q    <= 1'b0;
         buf_q      <= 1'b0;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         haddr_q    <= haddr_d;
         hsize_q    <= hsize_d;
         hwrite_q   <= hwrite_d;
         legal_q    <= legal_d;
         buf_q      <= buf_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

endmodule : ahb_slave_frontend
